// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, reset PC, bubble encoding
// and the IF/ID bundle used by fetch, decode and hazard detection.
package riscv_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  // Instructions are word aligned; the low two target bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, with async clear.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select (redirect > stall > advance)
// and the IF/ID pipeline register, plus stall/flush performance counters.
module if_stage
  import riscv_pkg::*;
#(
  parameter int                XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0]       NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            stall,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] BR_TARGET,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic [31:0]     IMEM_DATA,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [31:0]     IF_ID_INSTR,
  output logic            IF_ID_VALID,
  output logic            MISALIGN,
  output logic [31:0]     STALL_CNT,
  output logic [31:0]     FLUSH_CNT
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] if_id_pc_q;
  logic [31:0]     if_id_instr_q;
  logic            if_id_valid_q;
  logic            misalign_q;
  logic            stall_event;

  // A redirect outranks a stall, so a stalled cycle with PCSrc set is a flush.
  assign stall_event = stall & ~PCSrc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else if (PCSrc) begin
      pc_q          <= {BR_TARGET[XLEN-1:2], 2'b00};
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      if (BR_TARGET[1:0] != 2'b00) begin
        misalign_q <= 1'b1;
      end
    end else if (!stall) begin
      pc_q          <= pc_q + PC_STEP;
      if_id_pc_q    <= pc_q;
      if_id_instr_q <= IMEM_DATA;
      if_id_valid_q <= 1'b1;
    end
  end

  // Fetch address comes straight from the register; redirect only affects next PC.
  assign IMEM_ADDR   = pc_q;
  assign IF_ID_PC    = if_id_pc_q;
  assign IF_ID_INSTR = if_id_instr_q;
  assign IF_ID_VALID = if_id_valid_q;
  assign MISALIGN    = misalign_q;

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (stall_event),
    .count (STALL_CNT)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (PCSrc),
    .count (FLUSH_CNT)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed steps push expected observations into a queue,
// a monitor pops one per clock edge and compares against the DUT outputs.
module tb_if_stage;

  localparam int          EXP_W  = 162;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] TAG    = 32'hA000_0000;

  logic        CLK;
  logic        RST;
  logic        stall;
  logic        PCSrc;
  logic [31:0] BR_TARGET;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_INSTR;
  logic        IF_ID_VALID;
  logic        MISALIGN;
  logic [31:0] STALL_CNT;
  logic [31:0] FLUSH_CNT;

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int               n_checks = 0;
  int               n_errors = 0;

  // Reference state for the expected observations.
  logic [31:0] m_pc, m_if_pc, m_instr, m_sc, m_fc;
  logic        m_valid, m_mis;

  if_stage dut (
    .CLK         (CLK),
    .RST         (RST),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .BR_TARGET   (BR_TARGET),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_DATA   (IMEM_DATA),
    .IF_ID_PC    (IF_ID_PC),
    .IF_ID_INSTR (IF_ID_INSTR),
    .IF_ID_VALID (IF_ID_VALID),
    .MISALIGN    (MISALIGN),
    .STALL_CNT   (STALL_CNT),
    .FLUSH_CNT   (FLUSH_CNT)
  );

  assign IMEM_DATA = IMEM_ADDR | TAG;

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [EXP_W-1:0] pack_obs(
    input logic [31:0] addr, input logic [31:0] ipc, input logic [31:0] instr,
    input logic valid, input logic mis, input logic [31:0] sc, input logic [31:0] fc);
    return {addr, ipc, instr, valid, mis, sc, fc};
  endfunction

  function automatic logic [EXP_W-1:0] dut_obs();
    return pack_obs(IMEM_ADDR, IF_ID_PC, IF_ID_INSTR, IF_ID_VALID, MISALIGN,
                    STALL_CNT, FLUSH_CNT);
  endfunction

  task automatic check(input string name, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_if_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
    m_mis = 1'b0; m_sc = 32'h0; m_fc = 32'h0;
  endtask

  // Asserts reset mid-cycle, checks the async reset values, releases on a negedge.
  task automatic reset_dut(input string name);
    #2;
    RST = 1'b1;
    stall = 1'b0; PCSrc = 1'b0; BR_TARGET = 32'h0;
    #1;
    check(name, dut_obs(), pack_obs(32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'h0, 32'h0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  // Drives one cycle starting at a negedge; returns at the following negedge.
  task automatic step(input logic s, input logic p, input logic [31:0] t,
                      input string name);
    stall = s; PCSrc = p; BR_TARGET = t;
    if (p) begin
      m_pc = {t[31:2], 2'b00};
      m_if_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
      if (t[1:0] != 2'b00) m_mis = 1'b1;
    end else if (s) begin
      if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
    end else begin
      m_if_pc = m_pc; m_instr = m_pc | TAG; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    exp_q.push_back(pack_obs(m_pc, m_if_pc, m_instr, m_valid, m_mis, m_sc, m_fc));
    name_q.push_back(name);
    @(negedge CLK);
  endtask

  // Scoreboard monitor
  initial begin
    logic [EXP_W-1:0] e;
    string            n;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, dut_obs(), e);
      end
    end
  end

  // Directed stimulus
  initial begin
    RST = 1'b0; stall = 1'b0; PCSrc = 1'b0; BR_TARGET = 32'h0;
    model_reset();
    #1;
    reset_dut("reset_values");

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, "seq_advance");
    check("seq_if_pc", {130'h0, IF_ID_PC}, {130'h0, 32'd12});
    check("seq_imem_addr", {130'h0, IMEM_ADDR}, {130'h0, 32'd16});
    check("seq_instr", {130'h0, IF_ID_INSTR}, {130'h0, 32'hA000_000C});

    reset_dut("reset_again");
    step(1'b0, 1'b0, 32'h0, "pre_stall");
    step(1'b0, 1'b0, 32'h0, "pre_stall");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, "stall_hold");
    check("stall_cnt3", {130'h0, STALL_CNT}, {130'h0, 32'd3});
    check("stall_if_pc", {130'h0, IF_ID_PC}, {130'h0, 32'd4});
    check("stall_pc", {130'h0, IMEM_ADDR}, {130'h0, 32'd8});
    check("stall_instr", {130'h0, IF_ID_INSTR}, {130'h0, 32'hA000_0004});
    step(1'b0, 1'b0, 32'h0, "stall_release");
    check("release_if_pc", {130'h0, IF_ID_PC}, {130'h0, 32'd8});

    step(1'b0, 1'b1, 32'h0000_0100, "redirect_100");
    check("redir_pc", {130'h0, IMEM_ADDR}, {130'h0, 32'h100});
    check("redir_bubble", {129'h0, IF_ID_INSTR, IF_ID_VALID}, {129'h0, NOP, 1'b0});
    check("redir_flush_cnt", {130'h0, FLUSH_CNT}, {130'h0, 32'd1});
    step(1'b0, 1'b0, 32'h0, "after_redirect");
    check("redir_target_fetched", {129'h0, IF_ID_PC, IF_ID_VALID}, {129'h0, 32'h100, 1'b1});

    step(1'b1, 1'b1, 32'h0000_0200, "redirect_with_stall");
    check("rs_pc", {130'h0, IMEM_ADDR}, {130'h0, 32'h200});
    check("rs_stall_cnt", {130'h0, STALL_CNT}, {130'h0, 32'd3});
    check("rs_flush_cnt", {130'h0, FLUSH_CNT}, {130'h0, 32'd2});

    step(1'b0, 1'b1, 32'h0000_0102, "redirect_misaligned");
    check("mis_pc", {130'h0, IMEM_ADDR}, {130'h0, 32'h100});
    check("mis_flag", {161'h0, MISALIGN}, {161'h0, 1'b1});
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, "mis_sticky");
    check("mis_still_set", {161'h0, MISALIGN}, {161'h0, 1'b1});
    reset_dut("reset_clears_misalign");

    step(1'b0, 1'b1, 32'hFFFF_FFFC, "redirect_top");
    step(1'b0, 1'b0, 32'h0, "pc_wrap");
    check("wrap_pc", {130'h0, IMEM_ADDR}, {130'h0, 32'h0});
    check("wrap_if_pc", {130'h0, IF_ID_PC}, {130'h0, 32'hFFFF_FFFC});

    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    m_sc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, "stall_saturate");
    check("stall_cnt_sat", {130'h0, STALL_CNT}, {130'h0, 32'hFFFF_FFFF});

    step(1'b1, 1'b0, 32'h0, "stall_before_reset");
    reset_dut("reset_mid_stall");

    step(1'b0, 1'b0, 32'h0, "first_after_reset");
    check("first_valid", {129'h0, IF_ID_PC, IF_ID_VALID}, {129'h0, 32'h0, 1'b1});

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
